// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter: opcode set, FSM states, opcode legality.
package alu_pkg;
    localparam int ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_MAX = 4'd9;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
        XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9
    } alu_op_e;

    typedef enum logic {IDLE, HOLD} arb_state_e;

    function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
        return op > ALU_OP_MAX;
    endfunction
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way arbiter: single requester wins outright; ties go to 0 under fixed priority,
// otherwise to whichever requester was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: gnt = (fixed_prio || last_grant) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters; holds a single result until its owner
// consumes it, and accepts a new op in the same cycle for back-to-back throughput.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0][DATA_W-1:0]        req_a,
    input  logic [1:0][DATA_W-1:0]        req_b,
    input  logic [1:0][ALU_OP_W-1:0]      req_op,
    output logic [1:0]                    resp_valid,
    input  logic [1:0]                    resp_ready,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          resp_err,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    output logic [ALU_OP_W-1:0]           alu_op,
    input  logic [DATA_W-1:0]             alu_out,
    output logic                          busy
);
    arb_state_e state, state_nxt;
    logic       owner;
    logic       last_grant;
    logic       slot_free;
    logic [1:0] arb_req;
    logic [1:0] gnt_raw;
    logic [1:0] gnt;
    logic       grant_any;
    logic       g;

    // Requests are masked during reset so req_ready drops without waiting for a clock.
    assign arb_req = req_valid & {2{rst_n}};

    rr_arb2 u_arb (
        .req        (arb_req),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt        (gnt_raw)
    );

    assign gnt       = slot_free ? gnt_raw : 2'b00;
    assign grant_any = |gnt;
    assign g         = gnt[1];
    assign req_ready = gnt;

    assign alu_a  = grant_any ? req_a[g]  : '0;
    assign alu_b  = grant_any ? req_b[g]  : '0;
    assign alu_op = grant_any ? req_op[g] : '0;

    always_comb begin
        state_nxt  = state;
        resp_valid = 2'b00;
        busy       = 1'b0;
        slot_free  = 1'b1;
        if (state == HOLD) begin
            resp_valid[owner] = 1'b1;
            busy              = 1'b1;
            slot_free         = resp_ready[owner];
        end
        if (grant_any)
            state_nxt = HOLD;
        else if (state == HOLD && resp_ready[owner])
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                // Illegal opcodes are consumed but never expose whatever the ALU drives.
                resp_data  <= op_illegal(req_op[g]) ? '0 : alu_out;
                resp_err   <= op_illegal(req_op[g]);
                owner      <= g;
                last_grant <= g;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed checks of alu_arbiter (round-robin and fixed-priority instances)
// against a transaction-level model of the hold slot.
module tb_alu_arbiter;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_a, req_b;
    logic [1:0][3:0]   req_op;
    logic [1:0]        resp_ready;

    logic [1:0][1:0]   rdy, rv;
    logic [1:0][31:0]  rdata, alu_a, alu_b, alu_out;
    logic [1:0][3:0]   alu_op;
    logic [1:0]        rerr, bsy;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_held[2];
    bit          m_own[2];
    logic [31:0] m_dat[2];
    bit          m_err[2];
    bit          m_last[2];

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << b[4:0];
            4'd3: return {31'd0, $signed(a) < $signed(b)};
            4'd4: return {31'd0, a < b};
            4'd5: return a ^ b;
            4'd6: return a >> b[4:0];
            4'd7: return $signed(a) >>> b[4:0];
            4'd8: return a | b;
            4'd9: return a & b;
            default: return a ^ b ^ 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_out[0] = alu_fn(alu_a[0], alu_b[0], alu_op[0]);
    always_comb alu_out[1] = alu_fn(alu_a[1], alu_b[1], alu_op[1]);

    alu_arbiter #(.DATA_W(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(rv[0]),
        .resp_ready(resp_ready), .resp_data(rdata[0]), .resp_err(rerr[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_out(alu_out[0]),
        .busy(bsy[0]));

    alu_arbiter #(.DATA_W(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(rv[1]),
        .resp_ready(resp_ready), .resp_data(rdata[1]), .resp_err(rerr[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_out(alu_out[1]),
        .busy(bsy[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_held[m] = 0; m_own[m] = 0; m_dat[m] = '0; m_err[m] = 0; m_last[m] = 1;
        end
    endtask

    // Model m=0 is round-robin, m=1 fixed priority.
    function automatic logic [1:0] exp_gnt(input int m);
        if (!rst_n) return 2'b00;
        if (m_held[m] && !resp_ready[m_own[m]]) return 2'b00;
        case (req_valid)
            2'b01: return 2'b01;
            2'b10: return 2'b10;
            2'b11: return (m == 1 || m_last[m]) ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_outputs(input int m, input logic [1:0] eg);
        chk($sformatf("req_ready[%0d]", m), rdy[m], eg);
        chk($sformatf("resp_valid[%0d]", m), rv[m], m_held[m] ? (2'b01 << m_own[m]) : 2'b00);
        chk($sformatf("busy[%0d]", m), bsy[m], m_held[m]);
        if (m_held[m]) begin
            chk($sformatf("resp_data[%0d]", m), rdata[m], m_dat[m]);
            chk($sformatf("resp_err[%0d]", m), rerr[m], m_err[m]);
        end
    endtask

    // Called at a negedge; applies handshake inputs, checks, crosses one posedge, returns at negedge.
    task automatic run_cycle(input logic [1:0] v, input logic [1:0] rr, output logic [1:0] g0);
        logic [1:0] eg[2];
        req_valid  = v;
        resp_ready = rr;
        #1;
        for (int m = 0; m < 2; m++) begin
            eg[m] = exp_gnt(m);
            check_outputs(m, eg[m]);
        end
        g0 = eg[0];
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (eg[m] != 2'b00) begin
                int gi = eg[m][1] ? 1 : 0;
                m_held[m] = 1;
                m_own[m]  = eg[m][1];
                m_err[m]  = req_op[gi] > 4'd9;
                m_dat[m]  = m_err[m] ? 32'd0 : alu_fn(req_a[gi], req_b[gi], req_op[gi]);
                m_last[m] = eg[m][1];
            end else if (m_held[m] && rr[m_own[m]]) begin
                m_held[m] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]  g;
        logic [1:0]  seq[4];
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0;
        model_reset();
        #2;
        chk("rst_resp_valid", rv[0], 2'b00);
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_data", rdata[0], 32'd0);
        chk("rst_err", rerr[0], 1'b0);
        chk("rst_req_ready", rdy[0], 2'b00);
        chk("rst_req_ready_fp", rdy[1], 2'b00);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Single ADD 5+7
        req_a[0] = 32'd5; req_b[0] = 32'd7; req_op[0] = 4'd0;
        run_cycle(2'b01, 2'b00, g);
        chk("single_gnt", g, 2'b01);
        chk("single_valid", rv[0], 2'b01);
        chk("single_data", rdata[0], 32'd12);
        chk("single_err", rerr[0], 1'b0);
        chk("single_busy", bsy[0], 1'b1);
        run_cycle(2'b00, 2'b01, g);
        chk("single_idle", rv[0], 2'b00);

        // Ties from reset, always consuming
        do_reset();
        req_a[0] = 32'd1; req_b[0] = 32'd2; req_op[0] = 4'd0;
        req_a[1] = 32'd9; req_b[1] = 32'd4; req_op[1] = 4'd1;
        for (int i = 0; i < 4; i++) begin
            run_cycle(2'b11, 2'b11, g);
            seq[i] = g;
            chk("tie_nobubble", bsy[0], 1'b1);
        end
        chk("tie_order0", seq[0], 2'b01);
        chk("tie_order1", seq[1], 2'b10);
        chk("tie_order2", seq[2], 2'b01);
        chk("tie_order3", seq[3], 2'b10);
        run_cycle(2'b00, 2'b11, g);

        // Backpressure on requester 1: SUB 3-5
        req_a[1] = 32'd3; req_b[1] = 32'd5; req_op[1] = 4'd1;
        run_cycle(2'b10, 2'b00, g);
        for (int i = 0; i < 4; i++) begin
            run_cycle(2'b11, 2'b01, g);
            chk("bp_hold_data", rdata[0], 32'hFFFF_FFFE);
            chk("bp_ready_low", g, 2'b00);
        end
        run_cycle(2'b00, 2'b10, g);
        chk("bp_released", rv[0], 2'b00);

        // Illegal opcode
        req_a[0] = 32'h1234; req_b[0] = 32'h5678; req_op[0] = 4'd12;
        run_cycle(2'b01, 2'b00, g);
        chk("illegal_gnt", g, 2'b01);
        chk("illegal_data", rdata[0], 32'd0);
        chk("illegal_err", rerr[0], 1'b1);
        run_cycle(2'b00, 2'b01, g);

        // Fixed priority: three ties always go to requester 0 on dut_fp
        for (int i = 0; i < 3; i++) begin
            run_cycle(2'b11, 2'b11, g);
            chk("fp_owner", rv[1], 2'b01);
        end
        run_cycle(2'b00, 2'b11, g);

        // Reset between edges while holding
        req_op[1] = 4'd8;
        run_cycle(2'b10, 2'b00, g);
        chk("mid_pre_busy", bsy[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", rv[0], 2'b00);
        chk("mid_rst_busy", bsy[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(2'b11, 2'b11, g);
        chk("mid_rst_tie", g, 2'b01);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++) begin
                req_a[r]  = $urandom;
                req_b[r]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                req_op[r] = 4'($urandom_range(0, 15));
            end
            run_cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, 32, operand/result width.
REQ-002 Parameter FIXED_PRIO, 0, 1 = requester 0 always wins ties; 0 = round-robin.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  in  2  per-requester operation request.
REQ-006 req_ready  out  2  per-requester accept; transfer when valid and ready are both high.
REQ-007 req_a, req_b  in  2 x DATA_W  per-requester operands.
REQ-008 req_op  in  2 x 4  per-requester ALU opcode.
REQ-009 resp_valid  out  2  per-requester result available; at most one bit high.
REQ-010 resp_ready  in  2  per-requester result consumed.
REQ-011 resp_data  out  DATA_W  shared result register.
REQ-012 resp_err  out  1  held result came from an illegal opcode.
REQ-013 alu_a, alu_b  out  DATA_W  operands to the shared ALU.
REQ-014 alu_op  out  4  opcode to the shared ALU.
REQ-015 alu_out  in  DATA_W  combinational ALU result.
REQ-016 busy  out  1  high while a result is held (state HOLD).

Function
REQ-017 The block shall have two states: IDLE (no result held) and HOLD (result held for owner).
REQ-018 A slot is free when the state is IDLE, or when the state is HOLD and resp_valid[owner] and resp_ready[owner] are both high in the same cycle.
REQ-019 When the slot is free, the block shall grant exactly one valid requester; when it is not free, req_ready shall be 2'b00.
REQ-020 If only one requester is valid, it is granted. If both are valid, FIXED_PRIO=1 grants 0; FIXED_PRIO=0 grants the requester not granted most recently.
REQ-021 req_ready[g] shall be high only for the granted requester g; req_ready is combinational from req_valid, state and resp_ready.
REQ-022 alu_a/alu_b/alu_op shall mux from requester g while a grant is active; with no grant they shall be 0/0/4'd0.
REQ-023 At the grant edge: resp_data <= alu_out, owner <= g, resp_err <= (req_op[g] > 9), state <= HOLD. Latency is one cycle from acceptance to resp_valid.
REQ-024 Illegal opcodes 10..15 shall still be accepted, with resp_data = 0 and resp_err = 1.
REQ-025 In HOLD, resp_valid[owner] = 1 and resp_data/resp_err stay stable until consumed.
REQ-026 On consume with no new grant, state shall become IDLE and resp_valid 2'b00 on the next cycle.
REQ-027 On consume with a simultaneous grant (back-to-back), state shall stay HOLD with the new result/owner and no idle bubble, giving 1 op/cycle sustained.
REQ-028 The round-robin pointer (last_grant) shall update only on an actual transfer; resp_ready on the non-owner is ignored.
REQ-029 A requester dropping req_valid without a transfer shall leave all state unchanged.

Reset
REQ-030 When rst_n = 0: state IDLE, resp_valid 2'b00, resp_data 0, resp_err 0, owner 0, last_grant 1 (requester 0 wins the first tie), busy 0.
REQ-031 Reset asserted mid-HOLD shall discard the held result immediately, without waiting for a clock edge.
REQ-032 req_ready shall be 2'b00 while rst_n = 0.

Structure
REQ-033 Shared package alu_pkg shall hold: alu_op_e (ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9), ALU_OP_W=4, ALU_OP_MAX=9, and arb_state_e {IDLE, HOLD}.
REQ-034 Grant logic shall be a sub-module rr_arb2 (inputs: req[1:0], last_grant, fixed_prio; output: one-hot gnt[1:0]).
REQ-035 The ALU itself shall be instantiated outside this block and connected through the alu_* ports.

Verification
REQ-036 Single op: req0 ADD a=5, b=7 -> req_ready=01 that cycle; next cycle resp_valid=01, resp_data=12, resp_err=0, busy=1.
REQ-037 Tie: both valid from reset, with resp_ready held high -> grant order 0,1,0,1; results on consecutive cycles with no bubble.
REQ-038 Backpressure: req1 SUB 3-5 with resp_ready=0 for 4 cycles -> resp_data=0xFFFFFFFE held; req_ready=00 throughout; released on the cycle resp_ready[1]=1.
REQ-039 Illegal opcode: req0 op=12 -> accepted; resp_data=0, resp_err=1.
REQ-040 Reset mid-HOLD: assert rst_n low between clock edges -> resp_valid=00 and busy=0 immediately; first tie after release grants requester 0.
REQ-041 FIXED_PRIO=1, both requesters valid for 3 ops -> requester 0 granted every time.
